// File: rtl/tw_buf_gen.sv
// rtl/tw_buf_gen.sv - per-stage twiddle word buffer with entry/wrap/group sequencing
// Register table of half-word-writable twiddles read once per cycle at a stage-selected position.
module tw_buf_gen #(
  parameter int                   P_WIDTH    = 128,
  parameter int                   NSTAGE     = 4,
  parameter int                   NGRP       = 4,
  parameter int                   NENT       = 4,
  parameter int                   GRP_REP    = 16,
  parameter logic [NSTAGE-1:0]    GRP_MASK   = NSTAGE'(4'b0010),
  parameter logic [P_WIDTH-1:0]   IDLE_WORD  = P_WIDTH'(128'h1_0000000000000001),
  parameter logic [P_WIDTH-1:0]   CONST_INIT = P_WIDTH'(128'hfffffbff00000001_1fffffffe0000000),
  localparam int                  SW         = $clog2(NSTAGE),
  localparam int                  GW         = $clog2(NGRP),
  localparam int                  EW         = $clog2(NENT)
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   CEN,
  input  logic [SW:0]            stage_counter,
  input  logic                   rd_adv,
  input  logic                   wr_en,
  input  logic                   wr_half,
  input  logic [SW-1:0]          wr_stage,
  input  logic [GW-1:0]          wr_grp,
  input  logic [P_WIDTH/2-1:0]   wr_data,
  input  logic                   const_wr,
  input  logic [P_WIDTH-1:0]     const_data,
  output logic [P_WIDTH-1:0]     Q,
  output logic                   Q_valid,
  output logic [P_WIDTH-1:0]     Q_const
);

  localparam int                WW     = $clog2(GRP_REP);
  localparam logic [SW:0]       NST    = (SW+1)'(NSTAGE);
  localparam logic [EW-1:0]     EC_MAX = EW'(NENT-1);
  localparam logic [WW-1:0]     WC_MAX = WW'(GRP_REP-1);

  logic [P_WIDTH-1:0] mem_q   [NSTAGE][NGRP][NENT];
  logic [P_WIDTH-1:0] const_q [NSTAGE];
  logic [EW-1:0]      ec_q [NSTAGE], ec_d [NSTAGE];
  logic [WW-1:0]      wc_q [NSTAGE], wc_d [NSTAGE];
  logic [GW-1:0]      gi_q [NSTAGE], gi_d [NSTAGE];
  logic [EW-1:0]      wp_q;
  logic [SW:0]        stg_q;
  logic [P_WIDTH-1:0] q_q, q_const_q;
  logic               q_valid_q;

  logic          s_ok;
  logic          chg;
  logic [SW-1:0] sidx;

  assign s_ok = (stage_counter < NST);
  assign chg  = (stage_counter != stg_q);
  assign sidx = stage_counter[SW-1:0];

  always_comb begin
    ec_d = ec_q;
    wc_d = wc_q;
    gi_d = gi_q;
    if (!CEN) begin
      if (!s_ok) begin
        for (int i = 0; i < NSTAGE; i++) begin
          ec_d[i] = '0;
          wc_d[i] = '0;
          gi_d[i] = '0;
        end
      end else if (rd_adv) begin
        ec_d[sidx] = ec_q[sidx] + 1'b1;
        if (ec_q[sidx] == EC_MAX) begin
          wc_d[sidx] = (wc_q[sidx] == WC_MAX) ? '0 : wc_q[sidx] + 1'b1;
          if (wc_q[sidx] == WC_MAX && GRP_MASK[sidx])
            gi_d[sidx] = gi_q[sidx] + 1'b1;
        end
      end else begin
        ec_d[sidx] = '0;
      end
    end
    // A newly entered stage restarts its sequence; this cycle's read still used the old counters.
    if (chg && s_ok) begin
      ec_d[sidx] = '0;
      wc_d[sidx] = '0;
      gi_d[sidx] = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int s = 0; s < NSTAGE; s++) begin
        ec_q[s]    <= '0;
        wc_q[s]    <= '0;
        gi_q[s]    <= '0;
        const_q[s] <= CONST_INIT;
        for (int g = 0; g < NGRP; g++)
          for (int e = 0; e < NENT; e++)
            mem_q[s][g][e] <= (e == 0) ? IDLE_WORD : '0;
      end
      wp_q      <= '0;
      stg_q     <= '0;
      q_q       <= IDLE_WORD;
      q_valid_q <= 1'b0;
      q_const_q <= CONST_INIT;
    end else begin
      ec_q  <= ec_d;
      wc_q  <= wc_d;
      gi_q  <= gi_d;
      stg_q <= stage_counter;
      wp_q  <= wr_en ? wp_q + 1'b1 : '0;
      if (wr_en) begin
        if (wr_half)
          mem_q[wr_stage][wr_grp][wp_q][P_WIDTH/2-1:0] <= wr_data;
        else
          mem_q[wr_stage][wr_grp][wp_q][P_WIDTH-1:P_WIDTH/2] <= wr_data;
      end
      if (const_wr)
        const_q[wr_stage] <= const_data;
      if (!CEN && s_ok) begin
        q_q       <= mem_q[sidx][gi_q[sidx]][ec_q[sidx]];
        q_valid_q <= 1'b1;
        q_const_q <= (const_wr && wr_stage == sidx) ? const_data : const_q[sidx];
      end else begin
        q_q       <= IDLE_WORD;
        q_valid_q <= 1'b0;
      end
    end
  end

  assign Q       = q_q;
  assign Q_valid = q_valid_q;
  assign Q_const = q_const_q;

endmodule

// File: doc/tw_buf_gen.md
TW_BUF_GEN -- requirements
Module: tw_buf_gen

Interface
REQ-001 SHALL have parameter P_WIDTH, default 128, meaning twiddle word width (even).
REQ-002 SHALL have parameter NSTAGE, default 4, meaning number of stages served.
REQ-003 SHALL have parameter NGRP, default 4, meaning twiddle groups per stage (power of 2).
REQ-004 SHALL have parameter NENT, default 4, meaning entries per group (power of 2).
REQ-005 SHALL have parameter GRP_REP, default 16, meaning entry-counter wraps before the group advances.
REQ-006 SHALL have parameter GRP_MASK, default NSTAGE'b0010, meaning bit s=1 enables group advance for stage s.
REQ-007 SHALL have parameter IDLE_WORD, default 128'h1_0000000000000001, meaning unity word output when idle.
REQ-008 SHALL have parameter CONST_INIT, default 128'hfffffbff00000001_1fffffffe0000000, meaning reset value of every constant register.
REQ-009 SHALL have port CLK, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-010 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-011 SHALL have port CEN, input, 1, meaning active-low read enable.
REQ-012 SHALL have port stage_counter, input, clog2(NSTAGE)+1, meaning the current stage.
REQ-013 SHALL have port rd_adv, input, 1, meaning the entry counter may advance (FFT compute state).
REQ-014 SHALL have port wr_en, input, 1, meaning write beat valid.
REQ-015 SHALL have port wr_half, input, 1, meaning 0 = upper half [P_WIDTH-1:P_WIDTH/2], 1 = lower half.
REQ-016 SHALL have port wr_stage, input, clog2(NSTAGE), meaning target stage of the write.
REQ-017 SHALL have port wr_grp, input, clog2(NGRP), meaning target group of the write.
REQ-018 SHALL have port wr_data, input, P_WIDTH/2, meaning half-word write data.
REQ-019 SHALL have port const_wr, input, 1, meaning load const_data into const[wr_stage].
REQ-020 SHALL have port const_data, input, P_WIDTH, meaning constant write data.
REQ-021 SHALL have port Q, output, P_WIDTH, meaning twiddle word.
REQ-022 SHALL have port Q_valid, output, 1, meaning Q holds a table word (not IDLE_WORD).
REQ-023 SHALL have port Q_const, output, P_WIDTH, meaning per-stage constant.

Function
REQ-024 SHALL store NSTAGE x NGRP x NENT words of P_WIDTH bits in registers.
REQ-025 SHALL keep a write pointer wp (clog2(NENT) bits): it increments modulo NENT on each wr_en beat and clears to 0 in any cycle with wr_en=0.
REQ-026 SHALL, on a wr_en beat, write wr_data into the wr_half half of mem[wr_stage][wr_grp][wp] and leave the other half unchanged.
REQ-027 SHALL hold one entry counter ec, one wrap counter wc (0..GRP_REP-1) and one group index gi per stage.
REQ-028 SHALL, with CEN=0 and stage_counter=s<NSTAGE, register Q<=mem[s][gi[s]][ec[s]] and Q_valid<=1 (1-cycle latency).
REQ-029 SHALL, in the same cycle, set ec[s]<=ec[s]+1 modulo NENT if rd_adv=1, else ec[s]<=0.
REQ-030 SHALL, when ec[s] wraps from NENT-1, set wc[s]<=wc[s]+1 modulo GRP_REP.
REQ-031 SHALL, when ec[s] and wc[s] wrap in the same cycle and GRP_MASK[s]=1, set gi[s]<=gi[s]+1 modulo NGRP; when GRP_MASK[s]=0, gi[s] stays 0.
REQ-032 SHALL, with CEN=1, set Q<=IDLE_WORD and Q_valid<=0 and hold all counters.
REQ-033 SHALL, with CEN=0 and stage_counter>=NSTAGE, set Q<=IDLE_WORD and Q_valid<=0 and clear all ec, wc and gi.
REQ-034 SHALL clear ec, wc and gi of the new stage in the cycle after a change of stage_counter is registered; the read in the change cycle uses the existing counters.
REQ-035 SHALL return the pre-write contents to Q when a write and a read hit the same entry in the same cycle.
REQ-036 SHALL give const_wr priority over the same-cycle constant read; Q_const<=const[s] when CEN=0 and s<NSTAGE, otherwise Q_const holds its value.

Reset
REQ-037 SHALL, on rst=1 at a rising edge, set Q=IDLE_WORD, Q_valid=0, Q_const=CONST_INIT, all counters and wp=0, and all const[]=CONST_INIT.
REQ-038 SHALL, on reset, set entry 0 of every group to IDLE_WORD and all other entries to 0.
REQ-039 SHALL abort writes and reads in progress when reset is asserted mid-operation; no partial update survives.

Verification
REQ-040 SHALL be checked by: reset, then read stage 0 with CEN=0 and rd_adv=1 for 4 cycles -> Q = IDLE_WORD, 0, 0, 0 and Q_valid=1 from the second edge.
REQ-041 SHALL be checked by: 4 upper-half then 4 lower-half writes of value k+1 to stage 0 group 0 (wr_en dropped between the bursts) -> each entry k reads {k+1, k+1}.
REQ-042 SHALL be checked by: stage 1 with rd_adv=1 for 4*16 cycles -> gi[1] becomes 1 on the 64th cycle and the next read returns mem[1][1][0]; stage 0 stays at gi=0.
REQ-043 SHALL be checked by: rd_adv dropped at ec=2 -> next Q is entry 2, then entry 0.
REQ-044 SHALL be checked by: CEN=1 or stage_counter=7 -> Q=128'h1_0000000000000001 and Q_valid=0; stage 7 also clears the counters.
REQ-045 SHALL be checked by: const_wr to stage 1 with 128'hA5, then a stage-1 read -> Q_const=128'hA5; rst mid-burst -> all outputs at their reset values on the next edge.
